// File: rtl/camera_scroll_ctrl_pkg.sv
// Shared game parameters and the scroll controller state encoding.
package camera_scroll_ctrl_pkg;

    localparam int unsigned PHY_WIDTH    = 16;
    localparam int unsigned CAMERA_WIDTH = 6;
    localparam int unsigned BLOCK_WIDTH  = 480;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        REGEN      = 2'd2,
        COMMIT     = 2'd3
    } scroll_state_e;

endpackage

// File: rtl/scroll_req_slot.sv
// One-deep holding slot for a scroll request that arrives while the controller is busy.
module scroll_req_slot (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_dir,
    input  logic pop,
    output logic dir,
    output logic valid,
    output logic full
);

    logic valid_q, valid_d;
    logic dir_q, dir_d;

    // Pop then push in the same cycle leaves the slot holding the new entry.
    always_comb begin
        valid_d = valid_q;
        dir_d   = dir_q;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            valid_d = 1'b1;
            dir_d   = push_dir;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            dir_q   <= dir_d;
        end
    end

    assign dir   = dir_q;
    assign valid = valid_q;
    assign full  = valid_q;

endmodule

// File: rtl/camera_scroll_ctrl.sv
// Camera level stepping controller: request -> frame -> platform regen handshake -> frame commit.
module camera_scroll_ctrl #(
    parameter int unsigned PHY_WIDTH    = camera_scroll_ctrl_pkg::PHY_WIDTH,
    parameter int unsigned CAMERA_WIDTH = camera_scroll_ctrl_pkg::CAMERA_WIDTH,
    parameter int unsigned BLOCK_WIDTH  = camera_scroll_ctrl_pkg::BLOCK_WIDTH,
    parameter int          Y_INIT       = 10,
    parameter int unsigned ACK_TIMEOUT  = 1023
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    up_req,
    input  logic                    down_req,
    input  logic                    frame_tick,
    input  logic                    regen_ack,
    output logic                    regen_req,
    output logic                    regen_dir,
    output logic [CAMERA_WIDTH-1:0] camera_y,
    output logic [PHY_WIDTH:0]      abs_char_y,
    output logic                    busy,
    output logic [7:0]              reject_cnt,
    output logic                    err_timeout
);
    import camera_scroll_ctrl_pkg::*;

    localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PHY_WIDTH:0] BLOCK_STEP = (PHY_WIDTH + 1)'(BLOCK_WIDTH);

    scroll_state_e           state_q, state_d;
    logic                    dir_q, dir_d;
    logic [CAMERA_WIDTH-1:0] camera_q, camera_d;
    logic [PHY_WIDTH:0]      abs_q, abs_d;
    logic [7:0]              reject_q, reject_d;
    logic                    err_q, err_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    rdy_q, rdy_d;

    logic req_one, launch_en, launch_dir, launch_ok, reject_evt;
    logic slot_push, slot_pop, slot_dir, slot_valid, slot_full;

    // rdy_q stays low through the first clock after reset release so that cycle accepts nothing.
    assign req_one    = rdy_q & (up_req ^ down_req);
    assign launch_dir = slot_valid ? slot_dir : up_req;
    assign launch_en  = slot_valid | req_one;
    assign launch_ok  = launch_dir ? (camera_q != '1) : (camera_q != '0);

    scroll_req_slot u_slot (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .push     (slot_push),
        .push_dir (up_req),
        .pop      (slot_pop),
        .dir      (slot_dir),
        .valid    (slot_valid),
        .full     (slot_full)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            camera_q <= '0;
            abs_q    <= (PHY_WIDTH + 1)'(Y_INIT);
            reject_q <= '0;
            err_q    <= 1'b0;
            wait_q   <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            camera_q <= camera_d;
            abs_q    <= abs_d;
            reject_q <= reject_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        camera_d   = camera_q;
        abs_d      = abs_q;
        err_d      = err_q;
        wait_d     = wait_q;
        rdy_d      = 1'b1;
        slot_push  = 1'b0;
        slot_pop   = 1'b0;
        reject_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A held request launches first; a fresh request in that cycle refills the slot.
                slot_pop  = slot_valid;
                slot_push = slot_valid & req_one;
                if (launch_en) begin
                    if (launch_ok) begin
                        dir_d   = launch_dir;
                        state_d = WAIT_FRAME;
                    end else begin
                        reject_evt = 1'b1;
                    end
                end
            end
            WAIT_FRAME: begin
                if (frame_tick) begin
                    state_d = REGEN;
                    wait_d  = '0;
                end
            end
            REGEN: begin
                if (regen_ack) begin
                    state_d = COMMIT;
                end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            COMMIT: begin
                if (frame_tick) begin
                    camera_d = dir_q ? camera_q + CAMERA_WIDTH'(1) : camera_q - CAMERA_WIDTH'(1);
                    abs_d    = dir_q ? abs_q + BLOCK_STEP : abs_q - BLOCK_STEP;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && req_one) begin
            slot_push  = ~slot_full;
            reject_evt = slot_full;
        end
        reject_d = (reject_evt && reject_q != 8'hFF) ? reject_q + 8'd1 : reject_q;
    end

    always_comb begin
        regen_req = 1'b0;
        busy      = 1'b0;
        if (state_q == REGEN) begin
            regen_req = 1'b1;
        end
        if (state_q != IDLE) begin
            busy = 1'b1;
        end
    end

    assign regen_dir   = dir_q;
    assign camera_y    = camera_q;
    assign abs_char_y  = abs_q;
    assign reject_cnt  = reject_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_camera_scroll_ctrl.sv
// Directed and random checks of camera_scroll_ctrl against a transaction-level model.
module tb_camera_scroll_ctrl;

    localparam int CAM_MAX = 63;
    localparam int Y0      = 10;
    localparam int BLK     = 480;
    localparam int TMO     = 1023;

    localparam int PH_IDLE   = 0;
    localparam int PH_FRAME  = 1;
    localparam int PH_REGEN  = 2;
    localparam int PH_COMMIT = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        up_req = 1'b0, down_req = 1'b0, frame_tick = 1'b0, regen_ack = 1'b0;
    logic        regen_req, regen_dir, busy, err_timeout;
    logic [5:0]  camera_y;
    logic [16:0] abs_char_y;
    logic [7:0]  reject_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // model: committed level, accepted-but-unfinished transfer phase, waiting request queue
    int cam_m, rej_m, phase_m, wait_m;
    bit err_m, dir_m, ready_m;
    bit q_m[$];

    camera_scroll_ctrl #(
        .PHY_WIDTH(16), .CAMERA_WIDTH(6), .BLOCK_WIDTH(480), .Y_INIT(10), .ACK_TIMEOUT(1023)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .up_req(up_req), .down_req(down_req),
        .frame_tick(frame_tick), .regen_ack(regen_ack), .regen_req(regen_req),
        .regen_dir(regen_dir), .camera_y(camera_y), .abs_char_y(abs_char_y), .busy(busy),
        .reject_cnt(reject_cnt), .err_timeout(err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cam_m = 0; rej_m = 0; err_m = 0; phase_m = PH_IDLE; wait_m = 0;
        dir_m = 0; ready_m = 0; q_m.delete();
    endtask

    task automatic reject();
        if (rej_m < 255) rej_m++;
    endtask

    task automatic try_launch(input bit d);
        if (d ? (cam_m < CAM_MAX) : (cam_m > 0)) begin
            dir_m = d; phase_m = PH_FRAME;
        end else begin
            reject();
        end
    endtask

    task automatic model_step(input bit up, input bit dn, input bit tick, input bit ack);
        bit one, was_busy;
        one = ready_m && (up ^ dn);
        was_busy = (phase_m != PH_IDLE);
        case (phase_m)
            PH_IDLE: begin
                if (q_m.size() > 0) begin
                    try_launch(q_m.pop_front());
                    if (one) q_m.push_back(up);
                end else if (one) begin
                    try_launch(up);
                end
            end
            PH_FRAME: if (tick) begin phase_m = PH_REGEN; wait_m = 0; end
            PH_REGEN: begin
                if (ack) phase_m = PH_COMMIT;
                else begin
                    wait_m++;
                    if (wait_m == TMO) begin phase_m = PH_IDLE; err_m = 1; end
                end
            end
            default: if (tick) begin cam_m += dir_m ? 1 : -1; phase_m = PH_IDLE; end
        endcase
        if (was_busy && one) begin
            if (q_m.size() == 0) q_m.push_back(up);
            else reject();
        end
        ready_m = 1;
    endtask

    task automatic check_all();
        chk("camera_y", 32'(camera_y), 32'(cam_m));
        chk("abs_char_y", 32'($signed(abs_char_y)), 32'(Y0 + BLK * cam_m));
        chk("busy", 32'(busy), 32'(phase_m != PH_IDLE));
        chk("regen_req", 32'(regen_req), 32'(phase_m == PH_REGEN));
        chk("reject_cnt", 32'(reject_cnt), 32'(rej_m));
        chk("err_timeout", 32'(err_timeout), 32'(err_m));
        if (phase_m == PH_REGEN) chk("regen_dir", 32'(regen_dir), 32'(dir_m));
    endtask

    task automatic step(input bit up, input bit dn, input bit tick, input bit ack);
        up_req = up; down_req = dn; frame_tick = tick; regen_ack = ack;
        @(posedge sys_clk);
        model_step(up, dn, tick, ack);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        up_req = 0; down_req = 0; frame_tick = 0; regen_ack = 0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        model_reset();
        check_all();
        chk("regen_dir_reset", 32'(regen_dir), 32'd0);
        sys_rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();
        step(1, 0, 0, 0);                       // release cycle: request ignored
        chk("release_ignored_busy", 32'(busy), 32'd0);

        // single step up
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        chk("up_camera", 32'(camera_y), 32'd1);
        chk("up_abs", 32'($signed(abs_char_y)), 32'd490);

        // floor reject
        do_reset();
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("floor_reject_cnt", 32'(reject_cnt), 32'd1);

        // queued request while in REGEN, third rejected, ack+tick together does not commit
        do_reset();
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        chk("queue_first_cam", 32'(camera_y), 32'd1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        chk("queue_second_cam", 32'(camera_y), 32'd2);
        chk("queue_second_abs", 32'($signed(abs_char_y)), 32'd970);
        chk("queue_reject_cnt", 32'(reject_cnt), 32'd1);

        // simultaneous requests, idle and busy
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);

        // ack timeout with regen_ack withheld; stray ack beforehand is ignored
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < TMO; i++) step(0, 0, 0, 0);
        chk("timeout_regen_req", 32'(regen_req), 32'd0);
        chk("timeout_err", 32'(err_timeout), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_cam", 32'(camera_y), 32'd3);

        // asynchronous reset while in COMMIT
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        sys_rst = 1'b1;
        #1;
        chk("async_rst_cam", 32'(camera_y), 32'd0);
        chk("async_rst_abs", 32'($signed(abs_char_y)), 32'd10);
        do_reset();
        step(0, 0, 0, 0);

        // climb to the ceiling, then one more up is rejected
        for (int i = 0; i < CAM_MAX; i++) begin
            step(1, 0, 0, 0);
            step(0, 0, 1, 0);
            step(0, 0, 0, 1);
            step(0, 0, 1, 0);
        end
        step(1, 0, 0, 0);
        chk("ceiling_cam", 32'(camera_y), 32'd63);
        chk("ceiling_reject", 32'(reject_cnt), 32'd1);

        // reject counter saturation at the floor
        do_reset();
        step(0, 0, 0, 0);
        for (int i = 0; i < 260; i++) step(0, 1, 0, 0);
        chk("reject_saturate", 32'(reject_cnt), 32'd255);

        // random traffic
        do_reset();
        step(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/camera_scroll_ctrl.md
CAMERA_SCROLL_CTRL -- requirements
Module: camera_scroll_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PHY_WIDTH, 16, unsigned physical coordinate width
- CAMERA_WIDTH, 6, camera level width
- BLOCK_WIDTH, 480, vertical pixels per camera level
- Y_INIT, 10, abs_char_y reset value
- ACK_TIMEOUT, 1023, max cycles waiting for regen_ack
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- sys_clk, in, 1, system clock
- sys_rst, in, 1, reset; asynchronous, active-high
- up_req, in, 1, one-cycle step-up request (debounced edge)
- down_req, in, 1, one-cycle step-down request
- frame_tick, in, 1, one-cycle pulse at the frame boundary (vsync start)
- regen_ack, in, 1, one-cycle pulse: block generator has the new platform set ready
- regen_req, out, 1, level: regenerate platforms for target level
- regen_dir, out, 1, 1 = up, 0 = down; valid while regen_req is high
- camera_y, out, CAMERA_WIDTH, committed camera level
- abs_char_y, out, PHY_WIDTH+1, signed committed reference y
- busy, out, 1, high whenever state is not IDLE
- reject_cnt, out, 8, saturating count of rejected requests
- err_timeout, out, 1, sticky; ack timeout occurred

Function
REQ-003 The FSM SHALL have four states, IDLE, WAIT_FRAME, REGEN and COMMIT, with binary encoding.
REQ-004 In IDLE, a valid request SHALL latch its direction and move to WAIT_FRAME on the next cycle.
REQ-005 Validity rules: up is invalid when camera_y = 2^CAMERA_WIDTH-1, and down is invalid when camera_y = 0. An invalid request SHALL increment reject_cnt and cause no state change.
REQ-006 up_req and down_req asserted in the same cycle SHALL both be discarded, and no count is recorded.
REQ-007 WAIT_FRAME SHALL transition to REGEN on frame_tick. regen_req SHALL rise in the first REGEN cycle and hold, with a stable regen_dir, until the cycle regen_ack is sampled.
REQ-008 On regen_ack in REGEN, regen_req SHALL drop the next cycle and the state SHALL become COMMIT. A frame_tick in the same cycle as regen_ack SHALL NOT commit.
REQ-009 In COMMIT, on frame_tick, the up path SHALL apply camera_y+1 and abs_char_y+BLOCK_WIDTH, and the down path SHALL apply camera_y-1 and abs_char_y-BLOCK_WIDTH. Both outputs SHALL update in the same cycle, one cycle after the tick, and the state SHALL return to IDLE.
REQ-010 Camera and abs outputs SHALL change only at commit, never mid-frame.
REQ-011 A one-deep pending slot SHALL capture the first request arriving while busy. Further requests while the slot is full SHALL increment reject_cnt. Validity of the pending request SHALL be checked when it is launched from IDLE, against the updated camera_y.
REQ-012 reject_cnt SHALL saturate at 255.
REQ-013 The REGEN wait counter SHALL reset on entry to REGEN. Reaching ACK_TIMEOUT SHALL drop regen_req, set err_timeout, discard the target, and return to IDLE with camera_y and abs_char_y unchanged.
REQ-014 A regen_ack outside REGEN SHALL be ignored.
REQ-015 abs_char_y arithmetic SHALL be signed, PHY_WIDTH+1 bits. camera bounds guarantee no wrap.

Reset
REQ-016 sys_rst high SHALL asynchronously force: state IDLE, regen_req 0, regen_dir 0, camera_y 0, abs_char_y Y_INIT, busy 0, reject_cnt 0, err_timeout 0, and pending slot empty.
REQ-017 A reset mid-operation SHALL abandon any handshake. Release SHALL be synchronous to sys_clk, with no request accepted in the release cycle.

Structure
REQ-018 The FSM state encoding, CAMERA_WIDTH, PHY_WIDTH and BLOCK_WIDTH SHALL live in the shared game parameter package.
REQ-019 The one-deep pending slot SHALL be a sub-module, scroll_req_slot, with push, pop, dir, valid and full signals.

Verification
REQ-020 Single step up: after reset, one up_req, then frame_tick, then regen_ack (dir=1), then frame_tick. Required: camera_y=1 and abs_char_y=490, one cycle after the second tick.
REQ-021 Floor reject: at camera_y=0, one down_req. Required: reject_cnt=1, busy stays 0, regen_req never asserts.
REQ-022 Queue: an up_req while in REGEN, then a third up_req. Required: the first commits to camera_y=1, then the queued request commits to camera_y=2 and abs_char_y=970, and reject_cnt=1.
REQ-023 Timeout: enter REGEN and withhold regen_ack for 1023 cycles. Required: regen_req=0, err_timeout=1, state IDLE, camera_y unchanged.
REQ-024 Simultaneous and reset: up_req and down_req together produce no effect. Asserting sys_rst during COMMIT forces camera_y=0 and abs_char_y=10 immediately, without waiting for a clock.
